// File: rtl/cache_l1_pkg.sv
// Shared types and line-layout helpers for the set-associative L1 data cache.
// A stored line is packed as {valid, dirty, tag, lru, data}, data at bit 0.
package cache_l1_pkg;

   typedef enum logic [1:0] {IDLE, LOOKUP, WB, FILL} state_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

   function automatic int unsigned lru_lsb(input int unsigned data_w);
      return data_w;
   endfunction

   function automatic int unsigned tag_lsb(input int unsigned data_w, input int unsigned lru_w);
      return data_w + lru_w;
   endfunction

   function automatic int unsigned dirty_bit(input int unsigned addr_w, input int unsigned idx_w,
                                             input int unsigned lru_w, input int unsigned data_w);
      return data_w + lru_w + (addr_w - idx_w);
   endfunction

   function automatic int unsigned valid_bit(input int unsigned addr_w, input int unsigned idx_w,
                                             input int unsigned lru_w, input int unsigned data_w);
      return dirty_bit(addr_w, idx_w, lru_w, data_w) + 1;
   endfunction

   function automatic int unsigned line_w(input int unsigned addr_w, input int unsigned idx_w,
                                          input int unsigned lru_w, input int unsigned data_w);
      return dirty_bit(addr_w, idx_w, lru_w, data_w) + 2;
   endfunction

endpackage

// File: rtl/cache_l1_lru.sv
// True-LRU helper for one set: next counter vector for an access to `way`,
// and the replacement victim (lowest invalid way, else the least recent one).
module cache_l1_lru
   import cache_l1_pkg::*;
#(
   parameter int unsigned WAYS = 4,
   localparam int unsigned LRU_W = clog2(WAYS)
)(
   input  logic [WAYS*LRU_W-1:0] lru_in,
   input  logic [WAYS-1:0]       valid_in,
   input  logic [LRU_W-1:0]      way,
   output logic [WAYS*LRU_W-1:0] lru_out,
   output logic [LRU_W-1:0]      victim
);

   logic [LRU_W-1:0] cur;
   logic             found;

   always_comb begin
      cur = '0;
      for (int unsigned i = 0; i < WAYS; i++)
         if (LRU_W'(i) == way) cur = lru_in[i*LRU_W +: LRU_W];

      lru_out = lru_in;
      for (int unsigned i = 0; i < WAYS; i++) begin
         if (LRU_W'(i) == way)
            lru_out[i*LRU_W +: LRU_W] = '0;
         else if (lru_in[i*LRU_W +: LRU_W] < cur)
            lru_out[i*LRU_W +: LRU_W] = lru_in[i*LRU_W +: LRU_W] + LRU_W'(1);
      end

      victim = '0;
      found  = 1'b0;
      for (int unsigned i = 0; i < WAYS; i++)
         if (!valid_in[i] && !found) begin
            victim = LRU_W'(i);
            found  = 1'b1;
         end
      for (int unsigned i = 0; i < WAYS; i++)
         if (!found && lru_in[i*LRU_W +: LRU_W] == LRU_W'(WAYS-1)) begin
            victim = LRU_W'(i);
            found  = 1'b1;
         end
   end

endmodule

// File: rtl/cache_l1_assoc.sv
// N-way set-associative, write-back, write-allocate L1 data cache with true LRU;
// misses write back a dirty victim and fill over a req/ack memory handshake.
module cache_l1_assoc
   import cache_l1_pkg::*;
#(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SETS   = 4,
   parameter int unsigned WAYS   = 4
)(
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic              wren,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] q,
   output logic              done,
   output logic              hit,
   output logic              mem_req,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   localparam int unsigned IDX_W     = clog2(SETS);
   localparam int unsigned IW        = (IDX_W > 0) ? IDX_W : 1;
   localparam int unsigned LRU_W     = clog2(WAYS);
   localparam int unsigned TAG_W     = ADDR_W - IDX_W;
   localparam int unsigned LRU_LSB   = lru_lsb(DATA_W);
   localparam int unsigned TAG_LSB   = tag_lsb(DATA_W, LRU_W);
   localparam int unsigned DIRTY_BIT = dirty_bit(ADDR_W, IDX_W, LRU_W, DATA_W);
   localparam int unsigned VALID_BIT = valid_bit(ADDR_W, IDX_W, LRU_W, DATA_W);
   localparam int unsigned LINE_W    = line_w(ADDR_W, IDX_W, LRU_W, DATA_W);

   state_t              state;
   logic                wren_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   data_q;
   logic                first_q;
   logic [LRU_W-1:0]    victim_q;
   logic [LINE_W-1:0]   lines [SETS][WAYS];

   logic [IW-1:0]          idx;
   logic [TAG_W-1:0]       tag;
   logic                   hit_c;
   logic [LRU_W-1:0]       hit_way;
   logic [LRU_W-1:0]       victim_way;
   logic [WAYS-1:0]        set_valid;
   logic [WAYS*LRU_W-1:0]  set_lru;
   logic [WAYS*LRU_W-1:0]  lru_next;
   logic [ADDR_W-1:0]      wb_addr;

   generate
      if (IDX_W == 0) begin : g_full_assoc
         assign idx = '0;
      end else begin : g_set_assoc
         assign idx = addr_q[IDX_W-1:0];
      end
   endgenerate

   assign tag     = addr_q[ADDR_W-1:IDX_W];
   assign wb_addr = (ADDR_W'(lines[idx][victim_way][TAG_LSB +: TAG_W]) << IDX_W) | ADDR_W'(idx);

   always_comb begin
      hit_c     = 1'b0;
      hit_way   = '0;
      set_valid = '0;
      set_lru   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         set_valid[w]                 = lines[idx][w][VALID_BIT];
         set_lru[w*LRU_W +: LRU_W]    = lines[idx][w][LRU_LSB +: LRU_W];
         if (!hit_c && lines[idx][w][VALID_BIT] && lines[idx][w][TAG_LSB +: TAG_W] == tag) begin
            hit_c   = 1'b1;
            hit_way = LRU_W'(w);
         end
      end
   end

   cache_l1_lru #(.WAYS(WAYS)) u_lru (
      .lru_in   (set_lru),
      .valid_in (set_valid),
      .way      (hit_way),
      .lru_out  (lru_next),
      .victim   (victim_way)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         done      <= 1'b1;
         hit       <= 1'b0;
         q         <= '0;
         mem_req   <= 1'b0;
         mem_wren  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         wren_q    <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         first_q   <= 1'b0;
         victim_q  <= '0;
         for (int unsigned s = 0; s < SETS; s++)
            for (int unsigned w = 0; w < WAYS; w++)
               lines[s][w] <= LINE_W'(w) << LRU_LSB;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  wren_q  <= wren;
                  addr_q  <= address;
                  data_q  <= data;
                  first_q <= 1'b1;
                  done    <= 1'b0;
                  state   <= LOOKUP;
               end
            end
            LOOKUP: begin
               first_q <= 1'b0;
               if (hit_c) begin
                  for (int unsigned w = 0; w < WAYS; w++)
                     lines[idx][w][LRU_LSB +: LRU_W] <= lru_next[w*LRU_W +: LRU_W];
                  if (wren_q) begin
                     lines[idx][hit_way][DATA_W-1:0] <= data_q;
                     lines[idx][hit_way][DIRTY_BIT]  <= 1'b1;
                  end else begin
                     q <= lines[idx][hit_way][DATA_W-1:0];
                  end
                  // only a hit on the first lookup of the access counts as a hit
                  hit   <= first_q;
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  victim_q <= victim_way;
                  mem_req  <= 1'b1;
                  if (lines[idx][victim_way][DIRTY_BIT]) begin
                     mem_wren  <= 1'b1;
                     mem_addr  <= wb_addr;
                     mem_wdata <= lines[idx][victim_way][DATA_W-1:0];
                     state     <= WB;
                  end else begin
                     mem_wren <= 1'b0;
                     mem_addr <= addr_q;
                     state    <= FILL;
                  end
               end
            end
            WB: begin
               if (mem_ack) begin
                  lines[idx][victim_q][DIRTY_BIT] <= 1'b0;
                  mem_wren <= 1'b0;
                  mem_addr <= addr_q;
                  state    <= FILL;
               end
            end
            FILL: begin
               if (mem_ack) begin
                  lines[idx][victim_q][VALID_BIT]          <= 1'b1;
                  lines[idx][victim_q][DIRTY_BIT]          <= 1'b0;
                  lines[idx][victim_q][TAG_LSB +: TAG_W]   <= tag;
                  lines[idx][victim_q][DATA_W-1:0]         <= mem_rdata;
                  mem_req <= 1'b0;
                  state   <= LOOKUP;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_l1_assoc.sv
// Directed bench for cache_l1_assoc: default 4x4 instance plus a 2-way 8-set one,
// sharing a bench-side main memory where word a initially holds a ^ 8'h61.
module tb_cache_l1_assoc;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset = 1'b1;
   logic       sel = 1'b0;
   logic       req1 = 1'b0, req2 = 1'b0;
   logic       wren = 1'b0;
   logic [7:0] address = '0, data = '0, mem_rdata = '0;
   logic       resp_ack = 1'b0, stray_ack = 1'b0;
   logic       ack1, ack2;

   logic [7:0] q1, q2, maddr1, maddr2, mwdata1, mwdata2;
   logic       done1, done2, hit1, hit2, mreq1, mreq2, mwren1, mwren2;

   logic [7:0] c_q, r_addr, r_wdata;
   logic       c_done, c_hit, r_req, r_wren;

   int n_assert = 0, n_fail = 0;
   logic [7:0] mem [256];
   int   ack_dly = 3;
   bit   allow_drop = 1'b0;
   int   n_fill = 0, n_wb = 0;
   logic [7:0] last_fill_addr = '0, last_wb_addr = '0, last_wb_data = '0;
   bit   b2b_ok = 1'b0;
   logic [7:0] ra, rwd;
   logic       rw;
   bit         abort;

   assign ack1    = !sel && (resp_ack || stray_ack);
   assign ack2    =  sel && (resp_ack || stray_ack);
   assign c_q     = sel ? q2 : q1;
   assign c_done  = sel ? done2 : done1;
   assign c_hit   = sel ? hit2 : hit1;
   assign r_req   = sel ? mreq2 : mreq1;
   assign r_wren  = sel ? mwren2 : mwren1;
   assign r_addr  = sel ? maddr2 : maddr1;
   assign r_wdata = sel ? mwdata2 : mwdata1;

   cache_l1_assoc u1 (
      .clock(clock), .reset(reset), .req(req1), .wren(wren), .address(address), .data(data),
      .q(q1), .done(done1), .hit(hit1), .mem_req(mreq1), .mem_wren(mwren1), .mem_addr(maddr1),
      .mem_wdata(mwdata1), .mem_rdata(mem_rdata), .mem_ack(ack1)
   );

   cache_l1_assoc #(.ADDR_W(8), .DATA_W(8), .SETS(8), .WAYS(2)) u2 (
      .clock(clock), .reset(reset), .req(req2), .wren(wren), .address(address), .data(data),
      .q(q2), .done(done2), .hit(hit2), .mem_req(mreq2), .mem_wren(mwren2), .mem_addr(maddr2),
      .mem_wdata(mwdata2), .mem_rdata(mem_rdata), .mem_ack(ack2)
   );

   // memory responder: acks ack_dly cycles after seeing a request, checks it holds steady
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h61;
      forever begin
         @(posedge clock); #1;
         if (r_req === 1'b1) begin
            ra = r_addr; rw = r_wren; rwd = r_wdata; abort = 1'b0;
            for (int i = 0; i < ack_dly && !abort; i++) begin
               @(posedge clock); #1;
               if (r_req !== 1'b1) begin
                  abort = 1'b1;
                  if (!allow_drop) begin
                     n_assert++; n_fail++;
                     $display("FAIL mem_req_hold: mem_req=%b before ack, required 1", r_req);
                  end
               end else begin
                  n_assert++;
                  if (r_addr !== ra || r_wren !== rw || (rw && r_wdata !== rwd)) begin
                     n_fail++;
                     $display("FAIL mem_stable: addr=%h wren=%b wdata=%h, required %h %b %h",
                              r_addr, r_wren, r_wdata, ra, rw, rwd);
                  end
               end
            end
            if (!abort) begin
               mem_rdata = mem[ra];
               resp_ack  = 1'b1;
               @(posedge clock); #1;
               resp_ack = 1'b0;
               if (rw) begin
                  mem[ra] = rwd; n_wb++; last_wb_addr = ra; last_wb_data = rwd;
                  b2b_ok = (r_req === 1'b1 && r_wren === 1'b0);
               end else begin
                  n_fill++; last_fill_addr = ra;
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required finish");
      $fatal(1);
   end

   task automatic do_reset();
      @(posedge clock); #1;
      req1 = 1'b0; req2 = 1'b0; reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic access(input logic w, input logic [7:0] a, input logic [7:0] d, output int cyc);
      @(posedge clock); #1;
      wren = w; address = a; data = d;
      if (sel) req2 = 1'b1; else req1 = 1'b1;
      @(posedge clock); #1;
      req1 = 1'b0; req2 = 1'b0;
      cyc = 1;
      while (c_done !== 1'b1 && cyc < 300) begin
         @(posedge clock); #1;
         cyc++;
      end
      if (cyc >= 300) begin
         n_assert++; n_fail++;
         $display("FAIL access_timeout: addr=%h done=%b, required 1", a, c_done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      n_assert++; if (done1 !== 1'b1 || done2 !== 1'b1) begin n_fail++; $display("FAIL reset_done: got %b %b, required 1 1", done1, done2); end
      n_assert++; if (hit1 !== 1'b0 || hit2 !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b %b, required 0 0", hit1, hit2); end
      n_assert++; if (q1 !== 8'h00 || q2 !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h %h, required 00 00", q1, q2); end
      n_assert++; if (mreq1 !== 1'b0 || mwren1 !== 1'b0 || mreq2 !== 1'b0 || mwren2 !== 1'b0) begin
         n_fail++; $display("FAIL reset_mem_ctl: got %b%b %b%b, required 00 00", mreq1, mwren1, mreq2, mwren2); end
      n_assert++; if (maddr1 !== 8'h00 || mwdata1 !== 8'h00 || maddr2 !== 8'h00 || mwdata2 !== 8'h00) begin
         n_fail++; $display("FAIL reset_mem_bus: got %h %h %h %h, required 00", maddr1, mwdata1, maddr2, mwdata2); end
   endtask

   task automatic test_cold_read();
      int cyc, f0;
      do_reset();
      f0 = n_fill;
      access(1'b0, 8'h64, 8'h00, cyc);
      n_assert++; if (n_fill !== f0 + 1 || last_fill_addr !== 8'h64) begin n_fail++; $display("FAIL cold_fill: fills=%0d addr=%h, required %0d 64", n_fill - f0, last_fill_addr, 1); end
      n_assert++; if (c_hit !== 1'b0) begin n_fail++; $display("FAIL cold_hit: got %b, required 0", c_hit); end
      n_assert++; if (c_q !== 8'h05) begin n_fail++; $display("FAIL cold_q: got %h, required 05", c_q); end
      access(1'b0, 8'h64, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b1) begin n_fail++; $display("FAIL reread_hit: got %b, required 1", c_hit); end
      n_assert++; if (c_q !== 8'h05) begin n_fail++; $display("FAIL reread_q: got %h, required 05", c_q); end
      n_assert++; if (cyc !== 2) begin n_fail++; $display("FAIL hit_latency: got %0d, required 2", cyc); end
      n_assert++; if (n_fill !== f0 + 1) begin n_fail++; $display("FAIL reread_nomem: fills=%0d, required 1", n_fill - f0); end
   endtask

   task automatic test_writeback();
      int cyc, w0;
      do_reset();
      access(1'b0, 8'h64, 8'h00, cyc);
      access(1'b1, 8'h64, 8'h09, cyc);
      n_assert++; if (c_hit !== 1'b1) begin n_fail++; $display("FAIL wr_hit: got %b, required 1", c_hit); end
      access(1'b0, 8'h68, 8'h00, cyc);
      access(1'b0, 8'h6C, 8'h00, cyc);
      access(1'b0, 8'h70, 8'h00, cyc);
      n_assert++; if (c_q !== 8'h11 || c_hit !== 1'b0) begin n_fail++; $display("FAIL fill_70: q=%h hit=%b, required 11 0", c_q, c_hit); end
      w0 = n_wb;
      access(1'b0, 8'h74, 8'h00, cyc);
      n_assert++; if (n_wb !== w0 + 1 || last_wb_addr !== 8'h64 || last_wb_data !== 8'h09) begin
         n_fail++; $display("FAIL wb_victim: wbs=%0d addr=%h data=%h, required 1 64 09", n_wb - w0, last_wb_addr, last_wb_data); end
      n_assert++; if (b2b_ok !== 1'b1) begin n_fail++; $display("FAIL wb_to_fill: got %b, required 1", b2b_ok); end
      n_assert++; if (last_fill_addr !== 8'h74 || c_q !== 8'h15 || c_hit !== 1'b0) begin
         n_fail++; $display("FAIL wb_fill: addr=%h q=%h hit=%b, required 74 15 0", last_fill_addr, c_q, c_hit); end
   endtask

   task automatic test_lru_order();
      int cyc, w0;
      do_reset();
      access(1'b0, 8'h64, 8'h00, cyc);
      n_assert++; if (c_q !== 8'h09) begin n_fail++; $display("FAIL lru_fill64: got %h, required 09", c_q); end
      access(1'b0, 8'h68, 8'h00, cyc);
      access(1'b0, 8'h6C, 8'h00, cyc);
      access(1'b0, 8'h70, 8'h00, cyc);
      access(1'b0, 8'h64, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b1) begin n_fail++; $display("FAIL lru_touch64: got %b, required 1", c_hit); end
      w0 = n_wb;
      access(1'b0, 8'h74, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b0 || c_q !== 8'h15 || n_wb !== w0) begin
         n_fail++; $display("FAIL lru_miss74: hit=%b q=%h wbs=%0d, required 0 15 0", c_hit, c_q, n_wb - w0); end
      access(1'b0, 8'h64, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b1 || c_q !== 8'h09) begin n_fail++; $display("FAIL lru_keep64: hit=%b q=%h, required 1 09", c_hit, c_q); end
      access(1'b0, 8'h6C, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b1 || c_q !== 8'h0D) begin n_fail++; $display("FAIL lru_keep6c: hit=%b q=%h, required 1 0d", c_hit, c_q); end
      access(1'b0, 8'h68, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b0) begin n_fail++; $display("FAIL lru_evict68: hit=%b, required 0", c_hit); end
   endtask

   task automatic test_busy();
      int cyc, w0, f0, k;
      do_reset();
      access(1'b1, 8'h64, 8'h3C, cyc);
      n_assert++; if (c_hit !== 1'b0) begin n_fail++; $display("FAIL wr_miss_hit: got %b, required 0", c_hit); end
      access(1'b0, 8'h68, 8'h00, cyc);
      access(1'b0, 8'h6C, 8'h00, cyc);
      access(1'b0, 8'h70, 8'h00, cyc);
      ack_dly = 10; w0 = n_wb; f0 = n_fill;
      @(posedge clock); #1;
      wren = 1'b0; address = 8'h74; req1 = 1'b1;
      @(posedge clock); #1;
      req1 = 1'b0;
      k = 0;
      while (!(mreq1 === 1'b1 && mwren1 === 1'b1) && k < 20) begin @(posedge clock); #1; k++; end
      n_assert++; if (mwren1 !== 1'b1) begin n_fail++; $display("FAIL busy_wb_start: mem_wren=%b, required 1", mwren1); end
      wren = 1'b1; address = 8'h80; data = 8'hEE; req1 = 1'b1;
      @(posedge clock); #1;
      req1 = 1'b0; wren = 1'b0;
      cyc = 1;
      while (done1 !== 1'b1 && cyc < 300) begin @(posedge clock); #1; cyc++; end
      ack_dly = 3;
      n_assert++; if (cyc < 20 || cyc >= 300) begin n_fail++; $display("FAIL busy_wait: cycles=%0d, required 20..299", cyc); end
      n_assert++; if (n_wb !== w0 + 1 || last_wb_addr !== 8'h64 || last_wb_data !== 8'h3C) begin
         n_fail++; $display("FAIL busy_wb: wbs=%0d addr=%h data=%h, required 1 64 3c", n_wb - w0, last_wb_addr, last_wb_data); end
      n_assert++; if (n_fill !== f0 + 1 || last_fill_addr !== 8'h74 || q1 !== 8'h15 || hit1 !== 1'b0) begin
         n_fail++; $display("FAIL busy_ignore: fills=%0d addr=%h q=%h hit=%b, required 1 74 15 0", n_fill - f0, last_fill_addr, q1, hit1); end
      f0 = n_fill;
      @(posedge clock); #1; stray_ack = 1'b1;
      @(posedge clock); #1; stray_ack = 1'b0;
      n_assert++; if (done1 !== 1'b1 || mreq1 !== 1'b0) begin n_fail++; $display("FAIL stray_ack: done=%b mem_req=%b, required 1 0", done1, mreq1); end
      access(1'b0, 8'h74, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b1 || c_q !== 8'h15 || n_fill !== f0) begin
         n_fail++; $display("FAIL stray_after: hit=%b q=%h fills=%0d, required 1 15 0", c_hit, c_q, n_fill - f0); end
   endtask

   task automatic test_reset_mid();
      int cyc, k;
      do_reset();
      ack_dly = 20; allow_drop = 1'b1;
      @(posedge clock); #1;
      wren = 1'b0; address = 8'h64; req1 = 1'b1;
      @(posedge clock); #1;
      req1 = 1'b0;
      k = 0;
      while (mreq1 !== 1'b1 && k < 10) begin @(posedge clock); #1; k++; end
      n_assert++; if (mreq1 !== 1'b1 || mwren1 !== 1'b0) begin n_fail++; $display("FAIL mid_fill_req: req=%b wren=%b, required 1 0", mreq1, mwren1); end
      repeat (2) @(posedge clock);
      #1; reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      n_assert++; if (mreq1 !== 1'b0 || done1 !== 1'b1) begin n_fail++; $display("FAIL mid_reset: mem_req=%b done=%b, required 0 1", mreq1, done1); end
      @(posedge clock); #1;
      allow_drop = 1'b0; ack_dly = 3;
      access(1'b0, 8'h64, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b0 || c_q !== 8'h3C) begin n_fail++; $display("FAIL mid_reread: hit=%b q=%h, required 0 3c", c_hit, c_q); end
   endtask

   task automatic test_ways2();
      int cyc, w0;
      sel = 1'b1;
      do_reset();
      w0 = n_wb;
      access(1'b0, 8'h60, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b0 || c_q !== 8'h01) begin n_fail++; $display("FAIL w2_fill60: hit=%b q=%h, required 0 01", c_hit, c_q); end
      access(1'b0, 8'h68, 8'h00, cyc);
      access(1'b0, 8'h60, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b1) begin n_fail++; $display("FAIL w2_touch60: hit=%b, required 1", c_hit); end
      access(1'b0, 8'h70, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b0 || c_q !== 8'h11) begin n_fail++; $display("FAIL w2_miss70: hit=%b q=%h, required 0 11", c_hit, c_q); end
      access(1'b0, 8'h60, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b1 || c_q !== 8'h01) begin n_fail++; $display("FAIL w2_keep60: hit=%b q=%h, required 1 01", c_hit, c_q); end
      access(1'b0, 8'h61, 8'h00, cyc);
      access(1'b0, 8'h61, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b1 || c_q !== 8'h00) begin n_fail++; $display("FAIL w2_set1: hit=%b q=%h, required 1 00", c_hit, c_q); end
      access(1'b0, 8'h70, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b1) begin n_fail++; $display("FAIL w2_set0_intact: hit=%b, required 1", c_hit); end
      access(1'b0, 8'h68, 8'h00, cyc);
      n_assert++; if (c_hit !== 1'b0 || n_wb !== w0) begin n_fail++; $display("FAIL w2_evict68: hit=%b wbs=%0d, required 0 0", c_hit, n_wb - w0); end
      sel = 1'b0;
   endtask

   initial begin
      test_reset();
      test_cold_read();
      test_writeback();
      test_lru_order();
      test_busy();
      test_reset_mid();
      test_ways2();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
